heat_regulator: RTL and testbench

HEAT_REGULATOR -- requirements
Module: heat_regulator

---
 rtl/heat_regulator.sv | 162 ++++++++++++++++
 tb/tb_heat_regulator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/heat_regulator.sv
// Oven heat regulator: hysteresis bang-bang control with a minimum dwell time
// between heater switches, an over-temperature trip into a latched fault state,
// and a settled "at temperature" indication. All decisions are sampled on tick,
// except that dropping the operator switch leaves HOLD/HEAT immediately.
module heat_regulator #(
  parameter int HYST      = 4,    // hysteresis half-band in temperature units
  parameter int MIN_DWELL = 8,    // ticks required in HOLD/HEAT before a threshold switch
  parameter int MAX_TEMP  = 600,  // over-temperature trip level
  parameter int SETTLE    = 3     // consecutive in-band ticks before at_temp
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] input_temp,
  input  logic [9:0] oven_temp,
  input  logic       on_off_sw,
  input  logic       tick,
  output logic       heat,
  output logic       at_temp,
  output logic       fault,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_HEAT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // Counter widths: dwell is at least 4 bits, both wide enough for their limits.
  localparam int DW = ($clog2(MIN_DWELL + 1) > 4) ? $clog2(MIN_DWELL + 1) : 4;
  localparam int BW = ($clog2(SETTLE + 1) > 1) ? $clog2(SETTLE + 1) : 1;

  localparam logic [DW-1:0] DWELL_MAX  = DW'(MIN_DWELL);
  localparam logic [BW-1:0] SETTLE_MAX = BW'(SETTLE);
  localparam logic [10:0]   HYST_W     = 11'(HYST);
  localparam logic [31:0]   MAX_TEMP_U = 32'(MAX_TEMP);

  state_t        state_reg, state_next;
  logic [DW-1:0] dwell_reg, dwell_next;
  logic [BW-1:0] band_reg, band_next;
  logic          heat_reg, heat_next;
  logic          at_temp_reg, at_temp_next;
  logic          fault_reg, fault_next;

  logic [10:0] lower_wide;
  logic [10:0] upper_wide;
  logic [9:0]  lower;
  logic [9:0]  upper;
  logic        over_temp;
  logic        in_band;
  logic        below_lower;
  logic        above_upper;
  logic        regulating;
  logic        dwell_done;

  // Thresholds follow the live setpoint; 11-bit math exposes under/overflow
  // so both ends saturate instead of wrapping.
  always_comb begin
    lower_wide  = {1'b0, input_temp} - HYST_W;
    upper_wide  = {1'b0, input_temp} + HYST_W;
    lower       = lower_wide[10] ? 10'd0 : lower_wide[9:0];
    upper       = upper_wide[10] ? 10'd1023 : upper_wide[9:0];
    over_temp   = (32'(oven_temp) >= MAX_TEMP_U);
    in_band     = (oven_temp > lower) && (oven_temp < upper);
    below_lower = (oven_temp <= lower);
    above_upper = (oven_temp >= upper);
    regulating  = (state_reg == ST_HOLD) || (state_reg == ST_HEAT);
    dwell_done  = (dwell_reg == DWELL_MAX);
  end

  // Next-state logic. Order of checks encodes the priority: a ticked
  // over-temperature beats everything, then the operator switch, then the
  // hysteresis thresholds (which also need the dwell time to have elapsed).
  always_comb begin
    state_next = state_reg;
    dwell_next = dwell_reg;
    band_next  = band_reg;

    if (regulating && !on_off_sw && !(tick && over_temp)) begin
      // Switch-off is honoured on any cycle, tick or not, regardless of dwell.
      state_next = ST_OFF;
      dwell_next = '0;
      band_next  = '0;
    end else if (tick) begin
      if (over_temp) begin
        state_next = ST_FAULT;
        dwell_next = '0;
        band_next  = '0;
      end else begin
        unique case (state_reg)
          ST_OFF: begin
            if (on_off_sw) begin
              // Preloading the dwell lets the first HOLD tick start heating at once.
              state_next = ST_HOLD;
              dwell_next = DWELL_MAX;
            end
          end
          ST_FAULT: begin
            // Fault is latched until the operator switches off while cool.
            if (!on_off_sw) begin
              state_next = ST_OFF;
              band_next  = '0;
            end
          end
          default: begin
            // HOLD or HEAT with the switch on.
            if (in_band) begin
              band_next = (band_reg == SETTLE_MAX) ? band_reg : band_reg + BW'(1);
            end else begin
              band_next = '0;
            end

            if ((state_reg == ST_HOLD) && below_lower && dwell_done) begin
              state_next = ST_HEAT;
              dwell_next = '0;
            end else if ((state_reg == ST_HEAT) && above_upper && dwell_done) begin
              state_next = ST_HOLD;
              dwell_next = '0;
            end else if (!dwell_done) begin
              dwell_next = dwell_reg + DW'(1);
            end
          end
        endcase
      end
    end
  end

  // Output values derived from the next state so the registered outputs
  // always agree with the registered state.
  always_comb begin
    heat_next    = (state_next == ST_HEAT);
    fault_next   = (state_next == ST_FAULT);
    at_temp_next = (band_next == SETTLE_MAX) &&
                   ((state_next == ST_HOLD) || (state_next == ST_HEAT));
  end

  // State and output registers; reset acts immediately so heat drops at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_OFF;
      dwell_reg   <= '0;
      band_reg    <= '0;
      heat_reg    <= 1'b0;
      at_temp_reg <= 1'b0;
      fault_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dwell_reg   <= dwell_next;
      band_reg    <= band_next;
      heat_reg    <= heat_next;
      at_temp_reg <= at_temp_next;
      fault_reg   <= fault_next;
    end
  end

  assign heat    = heat_reg;
  assign at_temp = at_temp_reg;
  assign fault   = fault_reg;
  assign state   = state_reg;

endmodule

// File: tb/tb_heat_regulator.sv
// Testbench for heat_regulator: directed scenarios followed by randomized
// stimulus, all checked against a behavioural model. Two instances run in
// parallel, one with the default trip level and one with MAX_TEMP=1024.
module tb_heat_regulator;

  localparam int HYST      = 4;
  localparam int MIN_DWELL = 8;
  localparam int SETTLE    = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] input_temp = '0;
  logic [9:0] oven_temp = '0;
  logic       on_off_sw = 1'b0;
  logic       tick = 1'b0;

  logic       heat_lo, at_temp_lo, fault_lo;
  logic [1:0] state_lo;
  logic       heat_hi, at_temp_hi, fault_hi;
  logic [1:0] state_hi;

  int n_checks = 0;
  int n_errors = 0;
  int n_steps  = 0;

  // Model: mode 0=OFF 1=HOLD 2=HEAT 3=FAULT, plus dwell and in-band tick counts.
  typedef struct {
    int mode;
    int dwell;
    int band;
  } mdl_t;

  mdl_t m_lo, m_hi;

  heat_regulator dut_lo (
    .clock      (clock),
    .reset      (reset),
    .input_temp (input_temp),
    .oven_temp  (oven_temp),
    .on_off_sw  (on_off_sw),
    .tick       (tick),
    .heat       (heat_lo),
    .at_temp    (at_temp_lo),
    .fault      (fault_lo),
    .state      (state_lo)
  );

  heat_regulator #(.MAX_TEMP(1024)) dut_hi (
    .clock      (clock),
    .reset      (reset),
    .input_temp (input_temp),
    .oven_temp  (oven_temp),
    .on_off_sw  (on_off_sw),
    .tick       (tick),
    .heat       (heat_hi),
    .at_temp    (at_temp_hi),
    .fault      (fault_hi),
    .state      (state_hi)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of behaviour, written directly from the rules as plain arithmetic.
  function automatic mdl_t mdl_step(input mdl_t m, input int max_t, input int sp,
                                    input int ov, input bit sw, input bit tk);
    mdl_t n = m;
    int lo = (sp - HYST < 0) ? 0 : sp - HYST;
    int hi = (sp + HYST > 1023) ? 1023 : sp + HYST;
    bit on = (m.mode == 1) || (m.mode == 2);
    bit trip = tk && (ov >= max_t);
    if (on && !sw && !trip) begin
      n.mode = 0; n.dwell = 0; n.band = 0;
      return n;
    end
    if (!tk) return n;
    if (trip) begin
      n.mode = 3; n.dwell = 0; n.band = 0;
      return n;
    end
    if (m.mode == 0) begin
      if (sw) begin n.mode = 1; n.dwell = MIN_DWELL; end
    end else if (m.mode == 3) begin
      if (!sw) begin n.mode = 0; n.band = 0; end
    end else begin
      if (ov > lo && ov < hi) n.band = (m.band + 1 > SETTLE) ? SETTLE : m.band + 1;
      else n.band = 0;
      if (m.mode == 1 && ov <= lo && m.dwell == MIN_DWELL) begin
        n.mode = 2; n.dwell = 0;
      end else if (m.mode == 2 && ov >= hi && m.dwell == MIN_DWELL) begin
        n.mode = 1; n.dwell = 0;
      end else begin
        n.dwell = (m.dwell + 1 > MIN_DWELL) ? MIN_DWELL : m.dwell + 1;
      end
    end
    return n;
  endfunction

  function automatic int exp_at(input mdl_t m);
    return ((m.mode == 1 || m.mode == 2) && m.band == SETTLE) ? 1 : 0;
  endfunction

  task automatic check_outputs();
    check("lo_state", int'(state_lo), m_lo.mode);
    check("lo_heat", int'(heat_lo), (m_lo.mode == 2) ? 1 : 0);
    check("lo_fault", int'(fault_lo), (m_lo.mode == 3) ? 1 : 0);
    check("lo_at_temp", int'(at_temp_lo), exp_at(m_lo));
    check("hi_state", int'(state_hi), m_hi.mode);
    check("hi_heat", int'(heat_hi), (m_hi.mode == 2) ? 1 : 0);
    check("hi_fault", int'(fault_hi), (m_hi.mode == 3) ? 1 : 0);
    check("hi_at_temp", int'(at_temp_hi), exp_at(m_hi));
  endtask

  // Apply inputs, let one rising edge pass, advance the model, then compare.
  task automatic step(input int sp, input int ov, input bit sw, input bit tk);
    input_temp = 10'(sp);
    oven_temp  = 10'(ov);
    on_off_sw  = sw;
    tick       = tk;
    @(posedge clock);
    m_lo = mdl_step(m_lo, 600, sp, ov, sw, tk);
    m_hi = mdl_step(m_hi, 1024, sp, ov, sw, tk);
    #1;
    n_steps++;
    $display("step %0d sp=%0d ov=%0d sw=%0b tk=%0b | lo st=%0d h=%0b a=%0b f=%0b | hi st=%0d h=%0b a=%0b f=%0b",
             n_steps, sp, ov, sw, tk, state_lo, heat_lo, at_temp_lo, fault_lo,
             state_hi, heat_hi, at_temp_hi, fault_hi);
    check_outputs();
  endtask

  task automatic model_reset();
    m_lo = '{mode: 0, dwell: 0, band: 0};
    m_hi = '{mode: 0, dwell: 0, band: 0};
  endtask

  initial begin
    int sp;
    int ov;
    bit sw;
    bit tk;
    int r;

    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_outputs();
    reset = 1'b0;
    #1;
    check_outputs();

    // Heat-up from OFF: HOLD on the first tick, HEAT on the second.
    step(200, 150, 1, 1);
    check("heatup_t1_state", int'(state_lo), 1);
    step(200, 150, 1, 1);
    check("heatup_t2_state", int'(state_lo), 2);
    check("heatup_t2_heat", int'(heat_lo), 1);

    // Dwell: upper reached from the 3rd tick but HEAT holds until the 9th.
    step(200, 150, 1, 1);
    step(200, 150, 1, 1);
    for (int i = 3; i <= 8; i++) step(200, 204, 1, 1);
    check("dwell_t8_heat", int'(heat_lo), 1);
    step(200, 204, 1, 1);
    check("dwell_t9_state", int'(state_lo), 1);
    check("dwell_t9_heat", int'(heat_lo), 0);

    // Settling: three in-band ticks raise at_temp, the band edge clears it.
    step(200, 200, 1, 1);
    step(200, 200, 1, 1);
    check("settle_t2_at", int'(at_temp_lo), 0);
    step(200, 200, 1, 1);
    check("settle_t3_at", int'(at_temp_lo), 1);
    step(200, 204, 1, 1);
    check("settle_edge_at", int'(at_temp_lo), 0);

    // Back into HEAT, then over-temperature trip and latched fault.
    for (int i = 0; i < 12 && m_lo.mode != 2; i++) step(200, 150, 1, 1);
    check("pre_fault_state", int'(state_lo), 2);
    step(200, 600, 1, 1);
    check("trip_state", int'(state_lo), 3);
    check("trip_fault", int'(fault_lo), 1);
    check("trip_heat", int'(heat_lo), 0);
    step(200, 100, 1, 1);
    check("fault_hold_state", int'(state_lo), 3);
    step(200, 100, 0, 1);
    check("fault_exit_state", int'(state_lo), 0);

    // Lower threshold saturates at 0; upper saturates at 1023 (high-trip unit).
    step(2, 0, 1, 1);
    step(2, 0, 1, 1);
    check("sat_low_heat", int'(heat_lo), 1);
    for (int i = 1; i <= 8; i++) step(1022, 1023, 1, 1);
    check("sat_high_t8_heat", int'(heat_hi), 1);
    step(1022, 1023, 1, 1);
    check("sat_high_t9_state", int'(state_hi), 1);

    // Switch-off without tick; tick needed to leave OFF; trip beats switch-off.
    step(500, 100, 0, 1);
    step(500, 500, 1, 1);
    step(500, 500, 0, 0);
    check("untick_off_state", int'(state_lo), 0);
    step(500, 500, 1, 0);
    check("off_no_tick_state", int'(state_lo), 0);
    step(500, 500, 1, 1);
    step(500, 700, 0, 1);
    check("trip_priority_state", int'(state_lo), 3);
    step(500, 700, 0, 1);
    check("fault_hot_state", int'(state_lo), 3);
    step(500, 100, 0, 1);

    // Reset asserted mid-HEAT clears outputs without any clock edge.
    step(500, 100, 1, 1);
    step(500, 100, 1, 1);
    check("pre_reset_heat", int'(heat_lo), 1);
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_reset_heat", int'(heat_lo), 0);
    check("async_reset_state", int'(state_lo), 0);
    #1;
    reset = 1'b0;
    step(500, 100, 1, 0);
    check("post_reset_idle", int'(state_lo), 0);

    // Randomized run around the setpoint with occasional trips and switch-offs.
    sp = 300;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        r = $urandom_range(0, 3);
        if (r == 0) sp = $urandom_range(0, 6);
        else if (r == 1) sp = $urandom_range(1017, 1023);
        else sp = $urandom_range(0, 1023);
      end
      if ($urandom_range(0, 19) == 0) ov = $urandom_range(550, 1023);
      else begin
        ov = sp + $urandom_range(0, 20) - 10;
        if (ov < 0) ov = 0;
        if (ov > 1023) ov = 1023;
      end
      sw = ($urandom_range(0, 9) != 0);
      tk = ($urandom_range(0, 3) != 0);
      step(sp, ov, sw, tk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
